// File: rtl/x9_harness_pkg.sv
// Shared definitions for the X9 memory harness: sequencer state encoding,
// default bus widths and the run-cycle counter width.
package x9_harness_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int RUN_CW = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RSTC   = 3'd2,
    RUN    = 3'd3,
    DUMP   = 3'd4,
    FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/x9_mem_harness_if.sv
// Load, data-memory and dump signals between the X9 harness (master) and its
// environment (slave: image source, data memory, dump consumer).
//
// Handshakes (ld_* and dump_*): a beat transfers on a rising clk edge where
// valid and ready are both 1; valid never waits on ready, and while valid is
// high without ready the producer holds addr/data/last stable.
interface x9_mem_harness_if #(
  parameter int AW = x9_harness_pkg::AW_DEF,
  parameter int DW = x9_harness_pkg::DW_DEF
);
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_last;

  logic          dm_sel;
  logic          dm_wr_en;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wr_data;
  logic [DW-1:0] dm_rd_data;

  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;

  modport master (
    input  ld_valid, ld_addr, ld_data, ld_last, dm_rd_data, dump_ready,
    output ld_ready, dm_sel, dm_wr_en, dm_addr, dm_wr_data,
           dump_valid, dump_addr, dump_data, dump_last
  );

  modport slave (
    output ld_valid, ld_addr, ld_data, ld_last, dm_rd_data, dump_ready,
    input  ld_ready, dm_sel, dm_wr_en, dm_addr, dm_wr_data,
           dump_valid, dump_addr, dump_data, dump_last
  );

endinterface

// File: rtl/x9_watchdog.sv
// Saturating run-cycle counter. With X9_HARNESS_TIMEOUT_EN defined it also
// flags the cycle on whose closing edge the count reaches LIMIT.
module x9_watchdog
  import x9_harness_pkg::*;
#(
  parameter int W     = RUN_CW,
  parameter int LIMIT = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
`ifdef X9_HARNESS_TIMEOUT_EN
  output logic         reach,
`endif
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

`ifdef X9_HARNESS_TIMEOUT_EN
  // Look one increment ahead so the abort lands on the same edge the count hits LIMIT.
  logic [32:0] next_count;
  assign next_count = 33'(count) + 33'd1;
  assign reach      = en && (next_count >= 33'(LIMIT));
`endif

endmodule

// File: rtl/x9_mem_harness.sv
// Load/run/dump sequencer in front of the X9 core: writes a byte image into
// data memory, releases the core until done, then streams a memory window out.
// Optional RUN watchdog abort is compiled in with X9_HARNESS_TIMEOUT_EN.
module x9_mem_harness
  import x9_harness_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RST_CYCLES = 2,
  parameter int DUMP_LO    = 0,
  parameter int DUMP_HI    = 15,
  parameter int MAX_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  x9_mem_harness_if.master  bus,
  output logic              core_reset,
  input  logic              core_done,
  output logic              finished,
  output logic [RUN_CW-1:0] run_cycles,
`ifdef X9_HARNESS_TIMEOUT_EN
  output logic              timed_out,
`endif
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_LOAD   = LOAD;
  localparam logic [2:0] S_RSTC   = RSTC;
  localparam logic [2:0] S_RUN    = RUN;
  localparam logic [2:0] S_DUMP   = DUMP;
  localparam logic [2:0] S_FINISH = FINISH;

  localparam int            RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [AW-1:0]  PTR_LO   = AW'(DUMP_LO);
  localparam logic [AW-1:0]  PTR_HI   = AW'(DUMP_HI);

  logic [2:0]     state_q;
  logic [2:0]     state_d;
  logic [RCW-1:0] rst_cnt;
  logic [AW-1:0]  ptr;
  logic [DW-1:0]  rd_byte;

  logic in_load;
  logic in_run;
  logic in_dump;
  logic start_ok;
  logic beat_last;
  logic dump_fire;
  logic run_first;
  logic done_seen;
  logic abort;
  logic wd_clear;

  assign in_load   = (state_q == S_LOAD);
  assign in_run    = (state_q == S_RUN);
  assign in_dump   = (state_q == S_DUMP);
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_FINISH));
  assign beat_last = in_load && bus.ld_valid && bus.ld_last;
  assign dump_fire = in_dump && bus.dump_ready;

  // run_cycles is zero only during the first RUN cycle, so it doubles as the
  // mask for a done level left over from the previous program.
  assign run_first = (run_cycles == '0);
  assign done_seen = in_run && core_done && !run_first;
  assign wd_clear  = (state_q == S_IDLE) || start_ok;

`ifdef X9_HARNESS_TIMEOUT_EN
  logic wd_reach;

  x9_watchdog #(
    .W     (RUN_CW),
    .LIMIT (MAX_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (wd_clear),
    .en    (in_run),
    .reach (wd_reach),
    .count (run_cycles)
  );

  assign abort = wd_reach;
`else
  x9_watchdog #(
    .W     (RUN_CW),
    .LIMIT (MAX_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (wd_clear),
    .en    (in_run),
    .count (run_cycles)
  );

  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_LOAD;
      S_LOAD:   if (beat_last) state_d = S_RSTC;
      S_RSTC:   if (rst_cnt == RST_LAST) state_d = S_RUN;
      S_RUN:    if (done_seen || abort) state_d = S_DUMP;
      S_DUMP:   if (dump_fire && (ptr == PTR_HI)) state_d = S_FINISH;
      S_FINISH: if (start_ok) state_d = S_LOAD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rst_cnt <= '0;
      ptr     <= '0;
    end else begin
      state_q <= state_d;
      rst_cnt <= (state_q == S_RSTC) ? rst_cnt + RCW'(1) : '0;
      if (in_run && (state_d == S_DUMP)) begin
        ptr <= PTR_LO;
      end else if (dump_fire && (ptr != PTR_HI)) begin
        ptr <= ptr + AW'(1);
      end
    end
  end

`ifdef X9_HARNESS_TIMEOUT_EN
  // A done seen in the same cycle as expiry is a normal completion, not a timeout.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      timed_out <= 1'b0;
    end else if (in_run && abort && !done_seen) begin
      timed_out <= 1'b1;
    end
  end
`endif

  assign rd_byte = bus.dm_rd_data;

  assign bus.ld_ready   = in_load;
  assign bus.dm_sel     = !in_run;
  assign bus.dm_wr_en   = in_load && bus.ld_valid;
  assign bus.dm_addr    = in_load ? bus.ld_addr : ptr;
  assign bus.dm_wr_data = in_load ? bus.ld_data : '0;

  assign bus.dump_valid = in_dump;
  assign bus.dump_addr  = ptr;
  assign bus.dump_data  = in_dump ? rd_byte : '0;
  assign bus.dump_last  = in_dump && (ptr == PTR_HI);

  assign core_reset = !in_run;
  assign finished   = (state_q == S_FINISH);
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_x9_mem_harness.sv
// Bench for x9_mem_harness: data memory and stub core live here; a reference
// memory image predicts every dump window and run length.
module tb_x9_mem_harness;
  import x9_harness_pkg::*;

  localparam int AW         = 8;
  localparam int DW         = 8;
  localparam int RST_CYCLES = 2;
  localparam int DUMP_LO    = 0;
  localparam int DUMP_HI    = 7;
  localparam int MAX_CYCLES = 50;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        core_reset;
  logic        core_done;
  logic        finished;
  logic [15:0] run_cycles;
  logic [2:0]  fsm_state;
`ifdef X9_HARNESS_TIMEOUT_EN
  logic        timed_out;
`endif

  x9_mem_harness_if #(.AW(AW), .DW(DW)) bus ();

  x9_mem_harness #(
    .AW(AW), .DW(DW), .RST_CYCLES(RST_CYCLES),
    .DUMP_LO(DUMP_LO), .DUMP_HI(DUMP_HI), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .core_reset (core_reset),
    .core_done  (core_done),
    .finished   (finished),
    .run_cycles (run_cycles),
`ifdef X9_HARNESS_TIMEOUT_EN
    .timed_out  (timed_out),
`endif
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL tb_timeout observed=no_summary expected=summary");
    $fatal(1);
  end

  // ---------------- environment: data memory + stub core ----------------
  logic [DW-1:0] mem      [256];
  logic [DW-1:0] seed_mem [256];
  logic [DW-1:0] model_mem[256];
  logic          mem_fill = 1'b0;

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_mem[i];
    end else if (bus.dm_wr_en && bus.dm_sel) begin
      mem[bus.dm_addr] <= bus.dm_wr_data;
    end
  end
  assign bus.dm_rd_data = mem[bus.dm_addr];

  // done_at = N: core_done rises in the N-th cycle after release; 0 = never.
  int done_at = 0;
  int core_cnt = 0;
  always @(posedge clk) core_cnt <= core_reset ? 0 : core_cnt + 1;
  assign core_done = (done_at != 0) && !core_reset && (core_cnt >= done_at - 1);

  // ---------------- monitors ----------------
  int          wr_cnt = 0;
  int          stall_errs = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_beat = '0;
  logic [15:0] got_q[$];
  logic        last_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.dm_wr_en) wr_cnt++;
    if (reset) begin
      prev_stall = 1'b0;
    end else if (bus.dump_valid) begin
      if (prev_stall && ({bus.dump_addr, bus.dump_data} !== prev_beat)) stall_errs++;
      if (bus.dump_ready) begin
        got_q.push_back({bus.dump_addr, bus.dump_data});
        last_q.push_back(bus.dump_last);
      end
      prev_stall = !bus.dump_ready;
      prev_beat  = {bus.dump_addr, bus.dump_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int failures = 0;
  int beat_a[$];
  int beat_d[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_run_cycles(input int d);
    if (d == 0) return MAX_CYCLES;
    return (d < 2) ? 2 : d;
  endfunction

  task automatic random_beats(input int n, input int amax);
    beat_a.delete();
    beat_d.delete();
    for (int i = 0; i < n; i++) begin
      beat_a.push_back($urandom_range(0, amax));
      beat_d.push_back($urandom_range(0, 255));
    end
  endtask

  // Start pulse then back-to-back beats; returns 1 time unit after the last accept edge.
  task automatic send_load();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_to_load", fsm_state, LOAD);
    check("load_ready", bus.ld_ready, 1'b1);
    check("finished_cleared", finished, 1'b0);
    for (int i = 0; i < beat_a.size(); i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = beat_a[i][7:0];
      bus.ld_data  = beat_d[i][7:0];
      bus.ld_last  = (i == beat_a.size() - 1);
      model_mem[beat_a[i]] = beat_d[i][7:0];
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // mode 0: ready held 1; mode 1: ready 1,0,0,1 over dump cycles; mode 2: random.
  task automatic wait_finish(input int mode);
    int  k = 0;
    bit  seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      step();
      case (mode)
        0:       bus.dump_ready = 1'b1;
        1:       bus.dump_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: bus.dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.dump_valid) k++;
      @(negedge clk);
      if (finished) seen = 1;
    end
    check("finish_reached", finished, 1'b1);
    bus.dump_ready = 1'b0;
  endtask

  task automatic check_dump(input string tag);
    logic [15:0] g;
    logic [15:0] e;
    logic        l;
    exp_q.delete();
    for (int a = DUMP_LO; a <= DUMP_HI; a++) exp_q.push_back({8'(a), model_mem[a]});
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      l = last_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_beat"}, g, e);
      check({tag, "_last"}, l, (e[15:8] == 8'(DUMP_HI)));
    end
    check({tag, "_stall_stable"}, stall_errs, 0);
    check({tag, "_run_cycles"}, run_cycles, exp_run_cycles(done_at));
    check({tag, "_valid_low"}, bus.dump_valid, 1'b0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
`ifdef X9_HARNESS_TIMEOUT_EN
    check({tag, "_timed_out"}, timed_out, (done_at == 0));
`endif
    got_q.delete();
    last_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    bit found;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
    bus.dump_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      seed_mem[i]  = 8'($urandom_range(0, 255));
      model_mem[i] = seed_mem[i];
    end

    // reset state
    reset = 1'b1;
    mem_fill = 1'b1;
    step();
    mem_fill = 1'b0;
    step();
    @(negedge clk);
    check("rst_state", fsm_state, IDLE);
    check("rst_ld_ready", bus.ld_ready, 1'b0);
    check("rst_wr_en", bus.dm_wr_en, 1'b0);
    check("rst_dm_sel", bus.dm_sel, 1'b1);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_dump_valid", bus.dump_valid, 1'b0);
    check("rst_dump_last", bus.dump_last, 1'b0);
    check("rst_finished", finished, 1'b0);
    check("rst_run_cycles", run_cycles, 16'd0);
    step();
    reset = 1'b0;

    // directed image, done 20 cycles after release, ready held high
    beat_a = '{0, 1, 6, 7};
    beat_d = '{'hF0, 'h01, 'hAA, 'h55};
    done_at = 20;
    base = wr_cnt;
    send_load();
    @(negedge clk);
    check("a_rstc_state", fsm_state, RSTC);
    check("a_wr_cycles", wr_cnt - base, 4);
    for (int i = 0; i < 4; i++) check("a_mem", mem[beat_a[i]], model_mem[beat_a[i]]);
    check("a_core_reset_c1", core_reset, 1'b1);
    step();
    @(negedge clk);
    check("a_core_reset_c2", core_reset, 1'b1);
    step();
    @(negedge clk);
    check("a_released", core_reset, 1'b0);
    check("a_core_owns_mem", bus.dm_sel, 1'b0);
    check("a_run_state", fsm_state, RUN);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("a_start_ignored_in_run", fsm_state, RUN);
    wait_finish(0);
    check_dump("a");

    // ready toggling 1,0,0,1 while dumping
    random_beats(5, 9);
    done_at = 5;
    send_load();
    wait_finish(1);
    check_dump("b");

    // single-beat load; stale done level in the first RUN cycle
    beat_a = '{3};
    beat_d = '{$urandom_range(0, 255)};
    done_at = 1;
    base = wr_cnt;
    send_load();
    @(negedge clk);
    check("c_rstc_next_edge", fsm_state, RSTC);
    check("c_single_write", wr_cnt - base, 1);
    wait_finish(2);
    check_dump("c");

    // reset in the middle of a dump
    random_beats(4, 7);
    done_at = 6;
    send_load();
    bus.dump_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (bus.dump_valid && (bus.dump_addr == 8'd3)) found = 1;
    end
    check("d_reached_addr3", found, 1'b1);
    reset = 1'b1;
    bus.dump_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("d_idle", fsm_state, IDLE);
    check("d_dump_valid", bus.dump_valid, 1'b0);
    check("d_core_reset", core_reset, 1'b1);
    check("d_finished", finished, 1'b0);
    step();
    reset = 1'b0;
    got_q.delete();
    last_q.delete();
    random_beats(3, 7);
    done_at = 9;
    send_load();
    wait_finish(0);
    check_dump("d_restart");

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      random_beats($urandom_range(1, 6), 11);
      done_at = $urandom_range(1, 30);
      send_load();
      wait_finish($urandom_range(0, 2));
      check_dump("rand");
    end

`ifdef X9_HARNESS_TIMEOUT_EN
    // core never finishes: watchdog aborts into a full dump
    random_beats(3, 7);
    done_at = 0;
    send_load();
    wait_finish(0);
    check_dump("timeout");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
